mem_access: RTL and testbench
=============================

// Module: mem_access
// PURPOSE
//  Memory-access stage of the multi-cycle CPU; consumer end of the EXE->MEM bus.
//  Unpacks EXE_MEM_bus_r, drives the synchronous data RAM, aligns/extends load data.
//  Raises MEM_over once per instruction and packs MEM_WB_bus for write-back.
//  Sits between exe and wb; the top-level controller drives MEM_valid.
// PARAMETERS
//  LOAD_LAT  1  data-RAM read latency in cycles, >=1; MEM_over for a load comes LOAD_LAT cycles after issue
// PORTS
//  clk           in   1    clock; all state on posedge
//  resetn        in   1    asynchronous, active-low reset
//  MEM_valid     in   1    stage valid; level, held by controller until after MEM_over
//  EXE_MEM_bus_r in   106  {mem_control[3:0],store_data[31:0],alu_result[31:0],rf_wen,rf_wdest[4:0],pc[31:0]}
//  dm_rdata      in   32   data-RAM read data
//  dm_addr       out  32   {alu_result[31:2],2'b00}
//  dm_wen        out  4    per-byte write enable
//  dm_wdata      out  32   store data, byte-replicated for sb
//  MEM_over      out  1    instruction complete this cycle; one-cycle pulse
//  MEM_WB_bus    out  70   {rf_wen,rf_wdest[4:0],mem_result[31:0],pc[31:0]}; valid only while MEM_over=1
//  MEM_pc        out  32   pc field, for display
// BEHAVIOUR
//  mem_control bits: [3]=load, [2]=store, [1]=word (else byte), [0]=lb sign-extend.
//  Reset (async, resetn=0): state=IDLE, lat_cnt=0, byte_off=0.
//   Outputs during reset: MEM_over=0, dm_wen=0.
//   A reset mid-load aborts the load; no MEM_over is issued for it.
//  FSM states: IDLE, LOAD_WAIT, DONE.
//  IDLE & MEM_valid & !load & !store:
//   MEM_over=1 combinationally in the same cycle; mem_result=alu_result; next state DONE.
//  IDLE & MEM_valid & store:
//   dm_wen asserted for exactly this cycle; MEM_over=1 in the same cycle; next state DONE.
//   word store: dm_wen=4'b1111, dm_wdata=store_data.
//   byte store: dm_wen=4'b0001<<alu_result[1:0], dm_wdata={4{store_data[7:0]}}.
//  IDLE & MEM_valid & load:
//   read issued; byte_off<=alu_result[1:0]; lat_cnt<=LOAD_LAT-1; next state LOAD_WAIT.
//  LOAD_WAIT:
//   lat_cnt!=0: lat_cnt decrements each cycle.
//   lat_cnt==0: MEM_over=1, mem_result=extend(dm_rdata), next state DONE.
//  DONE: MEM_over=0, dm_wen=0; returns to IDLE on the first cycle with MEM_valid=0.
//   MEM_valid held high never yields a second MEM_over.
//  MEM_valid=0 in IDLE: no action; dm_wen=0, MEM_over=0.
//  extend() for word loads: dm_rdata unchanged.
//  extend() for byte loads: byte selected by byte_off.
//   Sign-extended when bit0=1 (lb), zero-extended otherwise (lbu).
//  Misaligned word access: low two address bits ignored. No exception is raised.
//  dm_addr is combinational from EXE_MEM_bus_r, which the controller holds stable while MEM_valid=1.
//  rf_wen, rf_wdest and pc pass through unchanged. rf_wen is not gated by the stage.
// STRUCTURE
//  Shared package: EXE_MEM_BUS_W=106, MEM_WB_BUS_W=70.
//   Also in the package: mem_control bit indices (MC_LOAD, MC_STORE, MC_WORD, MC_SIGN) and FSM state encodings.
//  One sub-module, load_ext: byte select plus sign/zero extend; combinational, shared with any future lh/lhu.
//  FSM and latency counter stay in mem_access.
// TESTING
//  1. add, alu_result=0x1234 -> MEM_over in the first MEM_valid cycle; mem_result=0x1234; dm_wen=0 throughout.
//  2. sw, addr=0x10, data=0xDEADBEEF -> one cycle of dm_wen=1111, dm_addr=0x10, MEM_over in the same cycle.
//  3. sb, addr=0x13, data=0x000000A5 -> dm_wen=1000, dm_wdata=0xA5A5A5A5, then no further write while MEM_valid held.
//  4. lb/lbu, addr=0x12, RAM word=0x0080FF00, LOAD_LAT=1 -> MEM_over one cycle after issue.
//     Expected: lb gives 0xFFFFFF80; lbu gives 0x00000080.
//  5. lw with LOAD_LAT=3 -> MEM_over exactly 3 cycles after issue, mem_result=RAM word.
//     Holding MEM_valid 5 more cycles gives no second MEM_over.
//  6. resetn pulsed low during LOAD_WAIT -> MEM_over never asserts.
//     FSM is in IDLE; next instruction after reset completes normally.

Source files
------------

// File: rtl/mem_access_pkg.sv
// Shared types for the memory-access stage.
// Bus layouts, mem_control bit positions and FSM encodings.
package mem_access_pkg;

  localparam int EXE_MEM_BUS_W = 106;
  localparam int MEM_WB_BUS_W  = 70;

  localparam int MC_LOAD  = 3;
  localparam int MC_STORE = 2;
  localparam int MC_WORD  = 1;
  localparam int MC_SIGN  = 0;

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_LOAD_WAIT = 2'd1,
    S_DONE      = 2'd2
  } state_t;

  typedef struct packed {
    logic [3:0]  mem_control;
    logic [31:0] store_data;
    logic [31:0] alu_result;
    logic        rf_wen;
    logic [4:0]  rf_wdest;
    logic [31:0] pc;
  } exe_mem_t;

  typedef struct packed {
    logic        rf_wen;
    logic [4:0]  rf_wdest;
    logic [31:0] mem_result;
    logic [31:0] pc;
  } mem_wb_t;

endpackage

// File: rtl/load_ext.sv
// Load-data aligner: byte select by offset plus sign/zero extension.
// Word loads pass the RAM word through untouched.
module load_ext (
  input  logic [31:0] i_rdata,
  input  logic [1:0]  i_off,
  input  logic        i_word,
  input  logic        i_sign,
  output logic [31:0] o_data
);

  logic [7:0] w_byte;

  always_comb begin
    w_byte = i_rdata[7:0];
    unique case (i_off)
      2'd0: w_byte = i_rdata[7:0];
      2'd1: w_byte = i_rdata[15:8];
      2'd2: w_byte = i_rdata[23:16];
      2'd3: w_byte = i_rdata[31:24];
      default: w_byte = i_rdata[7:0];
    endcase
  end

  assign o_data = i_word ? i_rdata
                : {{24{i_sign & w_byte[7]}}, w_byte};

endmodule

// File: rtl/mem_access.sv
// Memory-access stage: drives the data RAM and packs the write-back bus.
// Raises MEM_over exactly once per instruction.
module mem_access
  import mem_access_pkg::*;
#(
  parameter int LOAD_LAT = 1
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     MEM_valid,
  input  logic [EXE_MEM_BUS_W-1:0] EXE_MEM_bus_r,
  input  logic [31:0]              dm_rdata,
  output logic [31:0]              dm_addr,
  output logic [3:0]               dm_wen,
  output logic [31:0]              dm_wdata,
  output logic                     MEM_over,
  output logic [MEM_WB_BUS_W-1:0]  MEM_WB_bus,
  output logic [31:0]              MEM_pc
);

  localparam int CNT_W = (LOAD_LAT > 1) ? $clog2(LOAD_LAT) : 1;

  exe_mem_t         w_bus;
  mem_wb_t          w_wb;
  state_t           r_state;
  state_t           w_next;
  logic [CNT_W-1:0] r_lat_cnt;
  logic [1:0]       r_byte_off;
  logic             w_load;
  logic             w_store;
  logic             w_word;
  logic             w_sign;
  logic             w_cnt_zero;
  logic [31:0]      w_ld_data;

  assign w_bus      = EXE_MEM_bus_r;
  assign w_load     = w_bus.mem_control[MC_LOAD];
  assign w_store    = w_bus.mem_control[MC_STORE];
  assign w_word     = w_bus.mem_control[MC_WORD];
  assign w_sign     = w_bus.mem_control[MC_SIGN];
  assign w_cnt_zero = (r_lat_cnt == '0);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state    <= S_IDLE;
      r_lat_cnt  <= '0;
      r_byte_off <= 2'd0;
    end else begin
      r_state <= w_next;
      if (r_state == S_IDLE && MEM_valid && w_load) begin
        r_byte_off <= w_bus.alu_result[1:0];
        r_lat_cnt  <= CNT_W'(LOAD_LAT - 1);
      end else if (r_state == S_LOAD_WAIT && !w_cnt_zero) begin
        r_lat_cnt <= r_lat_cnt - 1'b1;
      end
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:
        if (MEM_valid) w_next = w_load ? S_LOAD_WAIT : S_DONE;
      S_LOAD_WAIT:
        if (w_cnt_zero) w_next = S_DONE;
      S_DONE:
        if (!MEM_valid) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // IDLE decode is gated by resetn so nothing escapes while held in reset
  always_comb begin
    MEM_over = 1'b0;
    dm_wen   = 4'b0000;
    unique case (r_state)
      S_IDLE:
        if (MEM_valid && resetn && !w_load) begin
          MEM_over = 1'b1;
          if (w_store)
            dm_wen = w_word ? 4'b1111
                   : 4'b0001 << w_bus.alu_result[1:0];
        end
      S_LOAD_WAIT:
        MEM_over = w_cnt_zero;
      default: ;
    endcase
  end

  assign dm_addr  = {w_bus.alu_result[31:2], 2'b00};
  assign dm_wdata = w_word ? w_bus.store_data
                  : {4{w_bus.store_data[7:0]}};

  load_ext u_load_ext (
    .i_rdata (dm_rdata),
    .i_off   (r_byte_off),
    .i_word  (w_word),
    .i_sign  (w_sign),
    .o_data  (w_ld_data)
  );

  assign w_wb.rf_wen     = w_bus.rf_wen;
  assign w_wb.rf_wdest   = w_bus.rf_wdest;
  assign w_wb.mem_result = w_load ? w_ld_data : w_bus.alu_result;
  assign w_wb.pc         = w_bus.pc;
  assign MEM_WB_bus      = w_wb;
  assign MEM_pc          = w_bus.pc;

endmodule

// File: tb/tb_mem_access.sv
// Directed bench for mem_access: ALU pass-through, stores, loads, reset abort.
// Two instances cover LOAD_LAT=1 and LOAD_LAT=3.
module tb_mem_access;
  import mem_access_pkg::*;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        v1 = 1'b0;
  logic        v3 = 1'b0;
  exe_mem_t    bus;
  logic [31:0] ram [0:63];
  logic [31:0] rd1, rd3;
  logic [31:0] addr1, addr3, wd1, wd3, pc1, pc3;
  logic [3:0]  wen1, wen3;
  logic        ov1, ov3;
  logic [69:0] wb1, wb3;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  mem_access #(.LOAD_LAT(1)) u_dut1 (
    .clk(clk), .resetn(resetn), .MEM_valid(v1),
    .EXE_MEM_bus_r(bus), .dm_rdata(rd1),
    .dm_addr(addr1), .dm_wen(wen1), .dm_wdata(wd1),
    .MEM_over(ov1), .MEM_WB_bus(wb1), .MEM_pc(pc1)
  );

  mem_access #(.LOAD_LAT(3)) u_dut3 (
    .clk(clk), .resetn(resetn), .MEM_valid(v3),
    .EXE_MEM_bus_r(bus), .dm_rdata(rd3),
    .dm_addr(addr3), .dm_wen(wen3), .dm_wdata(wd3),
    .MEM_over(ov3), .MEM_WB_bus(wb3), .MEM_pc(pc3)
  );

  always @(posedge clk) begin
    rd1 <= ram[addr1[7:2]];
    rd3 <= ram[addr3[7:2]];
  end

  task automatic chk(input string tag,
                     input logic [69:0] got,
                     input logic [69:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic exe_mem_t mk(input logic [3:0] mc,
                                  input logic [31:0] sd,
                                  input logic [31:0] alu,
                                  input logic [4:0] dst,
                                  input logic [31:0] pc);
    exe_mem_t b;
    b.mem_control = mc;
    b.store_data  = sd;
    b.alu_result  = alu;
    b.rf_wen      = 1'b1;
    b.rf_wdest    = dst;
    b.pc          = pc;
    return b;
  endfunction

  function automatic logic [69:0] wbx(input logic [4:0] dst,
                                      input logic [31:0] res,
                                      input logic [31:0] pc);
    return {1'b1, dst, res, pc};
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    v1 = 1'b0;
    v3 = 1'b0;
    cyc();
    cyc();
  endtask

  initial begin
    for (int i = 0; i < 64; i++) ram[i] = 32'h0;
    ram[4] = 32'h0080FF00;
    ram[5] = 32'hCAFEF00D;

    // held in reset with a store presented
    bus = mk(4'b0110, 32'h11223344, 32'h20, 5'd1, 32'h0);
    v1 = 1'b1;
    v3 = 1'b1;
    @(negedge clk);
    chk("rst_over1", 70'(ov1), 70'(0));
    chk("rst_wen1", 70'(wen1), 70'(0));
    chk("rst_over3", 70'(ov3), 70'(0));
    chk("rst_wen3", 70'(wen3), 70'(0));
    v1 = 1'b0;
    v3 = 1'b0;
    cyc();
    resetn = 1'b1;
    cyc();

    // add: completes in its first cycle, no write
    bus = mk(4'b0000, 32'h0, 32'h1234, 5'd5, 32'h100);
    v1 = 1'b1;
    @(negedge clk);
    chk("add_over", 70'(ov1), 70'(1));
    chk("add_wb", wb1, wbx(5'd5, 32'h1234, 32'h100));
    chk("add_wen", 70'(wen1), 70'(0));
    chk("add_pc", 70'(pc1), 70'(32'h100));
    cyc();
    @(negedge clk);
    chk("add_over2", 70'(ov1), 70'(0));
    chk("add_wen2", 70'(wen1), 70'(0));
    idle();

    // sw
    bus = mk(4'b0110, 32'hDEADBEEF, 32'h10, 5'd0, 32'h104);
    v1 = 1'b1;
    @(negedge clk);
    chk("sw_wen", 70'(wen1), 70'(4'b1111));
    chk("sw_addr", 70'(addr1), 70'(32'h10));
    chk("sw_wdata", 70'(wd1), 70'(32'hDEADBEEF));
    chk("sw_over", 70'(ov1), 70'(1));
    cyc();
    @(negedge clk);
    chk("sw_wen2", 70'(wen1), 70'(0));
    idle();

    // sb to byte 3, held valid
    bus = mk(4'b0100, 32'h000000A5, 32'h13, 5'd0, 32'h108);
    v1 = 1'b1;
    @(negedge clk);
    chk("sb_wen", 70'(wen1), 70'(4'b1000));
    chk("sb_wdata", 70'(wd1), 70'(32'hA5A5A5A5));
    chk("sb_addr", 70'(addr1), 70'(32'h10));
    chk("sb_over", 70'(ov1), 70'(1));
    for (int i = 0; i < 3; i++) begin
      cyc();
      @(negedge clk);
      chk("sb_hold_wen", 70'(wen1), 70'(0));
      chk("sb_hold_over", 70'(ov1), 70'(0));
    end
    idle();

    // lb from byte 2 of 0x0080FF00
    bus = mk(4'b1001, 32'h0, 32'h12, 5'd3, 32'h10C);
    v1 = 1'b1;
    @(negedge clk);
    chk("lb_over0", 70'(ov1), 70'(0));
    cyc();
    @(negedge clk);
    chk("lb_over1", 70'(ov1), 70'(1));
    chk("lb_wb", wb1, wbx(5'd3, 32'hFFFFFF80, 32'h10C));
    cyc();
    @(negedge clk);
    chk("lb_over2", 70'(ov1), 70'(0));
    idle();

    // lbu same address
    bus = mk(4'b1000, 32'h0, 32'h12, 5'd4, 32'h110);
    v1 = 1'b1;
    @(negedge clk);
    chk("lbu_over0", 70'(ov1), 70'(0));
    cyc();
    @(negedge clk);
    chk("lbu_over1", 70'(ov1), 70'(1));
    chk("lbu_wb", wb1, wbx(5'd4, 32'h00000080, 32'h110));
    idle();

    // lw, LOAD_LAT=3, misaligned address 0x16 reads word 0x14
    bus = mk(4'b1010, 32'h0, 32'h16, 5'd7, 32'h114);
    v3 = 1'b1;
    @(negedge clk);
    chk("lw_addr", 70'(addr3), 70'(32'h14));
    chk("lw_c0", 70'(ov3), 70'(0));
    for (int i = 1; i < 3; i++) begin
      cyc();
      @(negedge clk);
      chk("lw_wait", 70'(ov3), 70'(0));
    end
    cyc();
    @(negedge clk);
    chk("lw_over", 70'(ov3), 70'(1));
    chk("lw_wb", wb3, wbx(5'd7, 32'hCAFEF00D, 32'h114));
    for (int i = 0; i < 5; i++) begin
      cyc();
      @(negedge clk);
      chk("lw_hold", 70'(ov3), 70'(0));
    end
    idle();

    // reset during LOAD_WAIT aborts the load
    bus = mk(4'b1010, 32'h0, 32'h14, 5'd8, 32'h118);
    v3 = 1'b1;
    cyc();
    resetn = 1'b0;
    v3 = 1'b0;
    @(negedge clk);
    chk("abort_rst_over", 70'(ov3), 70'(0));
    chk("abort_rst_wen", 70'(wen3), 70'(0));
    cyc();
    resetn = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("abort_over", 70'(ov3), 70'(0));
      cyc();
    end

    // next instruction after reset completes at once
    bus = mk(4'b0000, 32'h0, 32'h55, 5'd9, 32'h11C);
    v3 = 1'b1;
    @(negedge clk);
    chk("post_over", 70'(ov3), 70'(1));
    chk("post_wb", wb3, wbx(5'd9, 32'h55, 32'h11C));
    idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
